// File: rtl/us256_interp_pkg.sv
// rtl/us256_interp_pkg.sv - shared constants, state enum and averaging helper
//
// Purpose : common definitions for the 3->4 upscaler.
//           - default input geometry (IN_W_DEF x IN_H_DEF)
//           - output geometry derivation (out_dim)
//           - line-phase state enum {ACTIVE, REPLAY}
//           - 8-bit two-tap average with a 9-bit sum and truncation
package us256_interp_pkg;

  localparam int IN_W_DEF = 192;
  localparam int IN_H_DEF = 144;
  localparam int PIX_W    = 8;

  // Every 3 input samples become 4 output samples.
  function automatic int out_dim(input int n);
    return (n * 4) / 3;
  endfunction

  localparam int OW_DEF = (IN_W_DEF * 4) / 3;
  localparam int OH_DEF = (IN_H_DEF * 4) / 3;

  // ACTIVE covers line phases 0..2 (input consumed), REPLAY is line phase 3.
  typedef enum logic {
    ACTIVE = 1'b0,
    REPLAY = 1'b1
  } state_t;

  // (a+b)>>1 with the carry kept, so 255+0 gives 127 and 1+2 gives 1.
  function automatic logic [PIX_W-1:0] avg8(input logic [PIX_W-1:0] a,
                                            input logic [PIX_W-1:0] b);
    logic [PIX_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[PIX_W:1];
  endfunction

endpackage

// File: rtl/us256_interp_if.sv
// rtl/us256_interp_if.sv - pixel stream interface of the 3->4 upscaler
//
// Purpose : bundles the input and output pixel streams.
// Signals : din/din_valid/din_ready         - input pixel stream (raster order)
//           dout/dout_valid/dout_ready      - output pixel stream
//           dout_sof                        - output pixel (0,0) of a frame
//           dout_eol                        - last output pixel of a line
// Modports: master - pixel source and sink (the environment)
//           slave  - the upscaler
interface us256_interp_if;
  import us256_interp_pkg::*;

  logic [PIX_W-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic [PIX_W-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             dout_sof;
  logic             dout_eol;

  modport master (
    output din, din_valid, dout_ready,
    input  din_ready, dout, dout_valid, dout_sof, dout_eol
  );

  modport slave (
    input  din, din_valid, dout_ready,
    output din_ready, dout, dout_valid, dout_sof, dout_eol
  );

endinterface

// File: rtl/us256_linebuf.sv
// rtl/us256_linebuf.sv - single-port line buffer with asynchronous read
//
// Purpose : holds one horizontally interpolated output line.
// Ports   : clk   - clock
//           we    - write enable, writes wdata to mem[addr] on the rising edge
//           addr  - shared read/write column address
//           wdata - word to store
//           rdata - current content of mem[addr] (combinational, so a same-
//                   cycle write still returns the old word)
// Contents are deliberately not reset.
module us256_linebuf #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH),
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/us256_interp.sv
// rtl/us256_interp.sv - 3->4 horizontal and vertical linear upscaler
//
// Purpose : upscales an IN_W x IN_H 8-bit frame to (IN_W*4/3) x (IN_H*4/3).
//           Horizontally each triple i0,i1,i2 becomes i0,avg(i0,i1),
//           avg(i1,i2),i2. Vertically each group of three lines becomes
//           h0, avg(h0,h1), avg(h1,h2), h2 using one line buffer.
// Ports   : clk - clock, rising edge
//           rst - synchronous active-high reset
//           bus - pixel stream interface (slave side)
module us256_interp
  import us256_interp_pkg::*;
#(
  parameter int IN_W = IN_W_DEF,
  parameter int IN_H = IN_H_DEF
) (
  input  logic          clk,
  input  logic          rst,
  us256_interp_if.slave bus
);

  localparam int OW = out_dim(IN_W);
  localparam int OH = out_dim(IN_H);
  localparam int XW = $clog2(OW);
  localparam int YW = $clog2(OH);
  localparam logic [XW-1:0] X_LAST = XW'(OW - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(OH - 1);

  state_t           state;
  logic [1:0]       hp;
  logic [1:0]       vp;
  logic [XW-1:0]    x;
  logic [YW-1:0]    y;
  logic [PIX_W-1:0] held;

  logic             slot_free;
  logic             take_input;
  logic             fire;
  logic             buf_we;
  logic [PIX_W-1:0] h;
  logic [PIX_W-1:0] m;
  logic [PIX_W-1:0] pix;

  // The output register can be loaded when empty or being drained.
  assign slot_free  = !bus.dout_valid || bus.dout_ready;
  // hp3 and the whole REPLAY line produce output without consuming input.
  assign take_input = (state == ACTIVE) && (hp != 2'd3);
  assign bus.din_ready = slot_free && take_input;
  assign fire       = slot_free && (!take_input || bus.din_valid);
  assign buf_we     = fire && (state == ACTIVE);

  // held carries the previous input of the triple (i0, i1, then i2 for hp3).
  always_comb begin
    h = held;
    case (hp)
      2'd0:       h = bus.din;
      2'd1, 2'd2: h = avg8(held, bus.din);
      default:    h = held;
    endcase

    pix = h;
    if (state == REPLAY) begin
      pix = m;
    end else if (vp != 2'd0) begin
      pix = avg8(m, h);
    end
  end

  us256_linebuf #(
    .DEPTH (OW),
    .AW    (XW),
    .DW    (PIX_W)
  ) u_linebuf (
    .clk   (clk),
    .we    (buf_we),
    .addr  (x),
    .wdata (h),
    .rdata (m)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ACTIVE;
      hp             <= 2'd0;
      vp             <= 2'd0;
      x              <= '0;
      y              <= '0;
      held           <= '0;
      bus.dout       <= '0;
      bus.dout_valid <= 1'b0;
      bus.dout_sof   <= 1'b0;
      bus.dout_eol   <= 1'b0;
    end else if (fire) begin
      bus.dout       <= pix;
      bus.dout_valid <= 1'b1;
      bus.dout_sof   <= (x == '0) && (y == '0);
      bus.dout_eol   <= (x == X_LAST);
      if (take_input) begin
        held <= bus.din;
      end
      // OW is a multiple of 4, so hp is back at 0 when REPLAY starts.
      if (state == ACTIVE) begin
        hp <= hp + 2'd1;
      end
      if (x == X_LAST) begin
        x <= '0;
        if (state == REPLAY) begin
          state <= ACTIVE;
          vp    <= 2'd0;
        end else if (vp == 2'd2) begin
          state <= REPLAY;
          vp    <= 2'd3;
        end else begin
          vp <= vp + 2'd1;
        end
        if (y == Y_LAST) begin
          y     <= '0;
          state <= ACTIVE;
          vp    <= 2'd0;
        end else begin
          y <= y + 1'b1;
        end
      end else begin
        x <= x + 1'b1;
      end
    end else if (bus.dout_ready) begin
      bus.dout_valid <= 1'b0;
    end
  end

endmodule
